// File: rtl/bullet_engine.sv
// Multi-channel bullet generator: each channel runs a ROM pattern, moves once per frame tick,
// handles arena edges (despawn, bounce or wrap) and raises a registered hit flag against the player box.
module bullet_engine #(
    parameter int NUM_CH        = 4,
    parameter int ARENA_W       = 160,
    parameter int ARENA_H       = 120,
    parameter int RESPAWN_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  isRun,
    input  logic                  frame_tick,
    input  logic [3*NUM_CH-1:0]   index,
    input  logic [15:0]           player_pos,
    input  logic [15:0]           player_size,
    output logic [16*NUM_CH-1:0]  position,
    output logic [16*NUM_CH-1:0]  size,
    output logic [3*NUM_CH-1:0]   color,
    output logic [NUM_CH-1:0]     isRender,
    output logic [NUM_CH-1:0]     hit
);

    localparam int CW = (RESPAWN_TICKS < 2) ? 1 : $clog2(RESPAWN_TICKS + 1);
    localparam logic signed [9:0] AW = 10'(ARENA_W);
    localparam logic signed [9:0] AH = 10'(ARENA_H);

    typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN} state_t;
    typedef enum logic [1:0] {M_DESPAWN, M_BOUNCE, M_WRAP} mode_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] w;
        logic [7:0] h;
        logic [2:0] col;
        mode_t      mode;
    } pat_t;

    function automatic pat_t rom(input logic [2:0] i);
        pat_t p;
        p = '{1'b0, 8'd0, 8'd0, 4'd0, 4'd0, 8'd0, 8'd0, 3'b000, M_DESPAWN};
        case (i)
            3'd1: p = '{1'b1, 8'd0,   8'd60, 4'd2, 4'd0, 8'd8, 8'd8, 3'b000, M_DESPAWN};
            3'd2: p = '{1'b1, 8'd0,   8'd0,  4'd1, 4'd1, 8'd4, 8'd4, 3'b001, M_BOUNCE};
            3'd3: p = '{1'b1, 8'd150, 8'd60, 4'hD, 4'd0, 8'd8, 8'd8, 3'b010, M_WRAP};
            default: ;
        endcase
        return p;
    endfunction

    logic       step;
    logic [7:0] px, py, pw, ph;

    assign step = frame_tick & isRun;
    assign px   = player_pos[15:8];
    assign py   = player_pos[7:0];
    assign pw   = player_size[15:8];
    assign ph   = player_size[7:0];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        state_t            st;
        mode_t             mode;
        logic [2:0]        idx, idx_q, col;
        logic [7:0]        x, y, w, h, mx, my;
        logic [3:0]        dx, dy, mdx, mdy;
        logic [CW-1:0]     cnt;
        logic              ren, hit_q, gone, overlap, restart, relaunch;
        logic signed [9:0] nx, ny, xmax, ymax;
        pat_t              cur, start, src;

        assign idx      = index[3*k +: 3];
        assign cur      = rom(idx);
        assign start    = rom(idx_q);
        assign restart  = (idx != idx_q) || (st == IDLE && cur.valid);
        assign relaunch = (st == COOLDOWN) && (cnt == '0) && start.valid;
        assign src      = restart ? cur : start;

        assign overlap = ({1'b0, x} < {1'b0, px} + {1'b0, pw}) &&
                         ({1'b0, px} < {1'b0, x} + {1'b0, w}) &&
                         ({1'b0, y} < {1'b0, py} + {1'b0, ph}) &&
                         ({1'b0, py} < {1'b0, y} + {1'b0, h});

        // Candidate next motion in 10-bit signed space so edge crossings are never lost to 8-bit wrap.
        always_comb begin
            nx   = $signed({2'b00, x}) + $signed({{6{dx[3]}}, dx});
            ny   = $signed({2'b00, y}) + $signed({{6{dy[3]}}, dy});
            xmax = AW - $signed({2'b00, w});
            ymax = AH - $signed({2'b00, h});
            mx   = nx[7:0];
            my   = ny[7:0];
            mdx  = dx;
            mdy  = dy;
            gone = 1'b0;
            case (mode)
                M_DESPAWN: gone = (nx < 10'sd0) || (nx > xmax) || (ny < 10'sd0) || (ny > ymax);
                M_BOUNCE: begin
                    if (nx < 10'sd0) begin
                        mx  = 8'd0;
                        mdx = -dx;
                    end else if (nx > xmax) begin
                        mx  = xmax[7:0];
                        mdx = -dx;
                    end
                    if (ny < 10'sd0) begin
                        my  = 8'd0;
                        mdy = -dy;
                    end else if (ny > ymax) begin
                        my  = ymax[7:0];
                        mdy = -dy;
                    end
                end
                M_WRAP: begin
                    if (nx < 10'sd0)    mx = 8'(nx + AW);
                    else if (nx >= AW)  mx = 8'(nx - AW);
                    if (ny < 10'sd0)    my = 8'(ny + AH);
                    else if (ny >= AH)  my = 8'(ny - AH);
                end
                default: ;
            endcase
        end

        // Index changes outrank everything, then cooldown relaunch, then motion and cooldown counting.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st    <= IDLE;
                mode  <= M_DESPAWN;
                idx_q <= 3'd0;
                x     <= 8'd0;
                y     <= 8'd0;
                w     <= 8'd0;
                h     <= 8'd0;
                dx    <= 4'd0;
                dy    <= 4'd0;
                col   <= 3'd0;
                cnt   <= '0;
                ren   <= 1'b0;
                hit_q <= 1'b0;
            end else begin
                idx_q <= idx;
                hit_q <= ren & overlap;
                if (restart && !cur.valid) begin
                    st  <= IDLE;
                    x   <= 8'd0;
                    y   <= 8'd0;
                    w   <= 8'd0;
                    h   <= 8'd0;
                    dx  <= 4'd0;
                    dy  <= 4'd0;
                    col <= 3'd0;
                    ren <= 1'b0;
                end else if (restart || relaunch) begin
                    st   <= ACTIVE;
                    x    <= src.x;
                    y    <= src.y;
                    w    <= src.w;
                    h    <= src.h;
                    dx   <= src.dx;
                    dy   <= src.dy;
                    col  <= src.col;
                    mode <= src.mode;
                    ren  <= 1'b1;
                end else if (st == ACTIVE && step) begin
                    if (gone) begin
                        st  <= COOLDOWN;
                        ren <= 1'b0;
                        cnt <= CW'(RESPAWN_TICKS);
                    end else begin
                        x  <= mx;
                        y  <= my;
                        dx <= mdx;
                        dy <= mdy;
                    end
                end else if (st == COOLDOWN && step) begin
                    cnt <= cnt - CW'(1);
                end
            end
        end

        assign position[16*k +: 16] = {x, y};
        assign size[16*k +: 16]     = {w, h};
        assign color[3*k +: 3]      = col;
        assign isRender[k]          = ren;
        assign hit[k]               = hit_q;
    end

endmodule

// File: tb/tb_bullet_engine.sv
// Self-checking bench for bullet_engine: directed pattern scenarios plus randomized traffic,
// compared every cycle against an integer-arithmetic model of the bullet rules.
module tb_bullet_engine;

    localparam int NUM_CH = 4;
    localparam int AW     = 160;
    localparam int AH     = 120;
    localparam int RT     = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 is_run = 1'b0;
    logic                 frame_tick = 1'b0;
    logic [3*NUM_CH-1:0]  index = '0;
    logic [15:0]          player_pos = '0;
    logic [15:0]          player_size = '0;
    logic [16*NUM_CH-1:0] position, size;
    logic [3*NUM_CH-1:0]  color;
    logic [NUM_CH-1:0]    is_render, hit;

    int checks = 0;
    int failures = 0;

    // Model state: st 0=idle 1=active 2=cooldown; mode equals the pattern number (1 despawn, 2 bounce, 3 wrap).
    int m_st[NUM_CH], m_x[NUM_CH], m_y[NUM_CH], m_dx[NUM_CH], m_dy[NUM_CH];
    int m_w[NUM_CH], m_h[NUM_CH], m_col[NUM_CH], m_mode[NUM_CH], m_cnt[NUM_CH];
    int m_ren[NUM_CH], m_idxq[NUM_CH], m_hit[NUM_CH];

    bullet_engine #(.NUM_CH(NUM_CH), .ARENA_W(AW), .ARENA_H(AH), .RESPAWN_TICKS(RT)) dut (
        .clk(clk), .rst_n(rst_n), .isRun(is_run), .frame_tick(frame_tick), .index(index),
        .player_pos(player_pos), .player_size(player_size), .position(position), .size(size),
        .color(color), .isRender(is_render), .hit(hit)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_st[k] = 0; m_x[k] = 0; m_y[k] = 0; m_dx[k] = 0; m_dy[k] = 0; m_w[k] = 0; m_h[k] = 0;
            m_col[k] = 0; m_mode[k] = 0; m_cnt[k] = 0; m_ren[k] = 0; m_idxq[k] = 0; m_hit[k] = 0;
        end
    endtask

    task automatic model_load(input int k, input int p);
        m_st[k] = 1; m_ren[k] = 1; m_mode[k] = p;
        case (p)
            1: begin m_x[k] = 0;   m_y[k] = 60; m_dx[k] = 2;  m_dy[k] = 0; m_w[k] = 8; m_h[k] = 8; m_col[k] = 0; end
            2: begin m_x[k] = 0;   m_y[k] = 0;  m_dx[k] = 1;  m_dy[k] = 1; m_w[k] = 4; m_h[k] = 4; m_col[k] = 1; end
            default: begin m_x[k] = 150; m_y[k] = 60; m_dx[k] = -3; m_dy[k] = 0; m_w[k] = 8; m_h[k] = 8; m_col[k] = 2; end
        endcase
    endtask

    task automatic model_move(input int k);
        int nx, ny, xmax, ymax;
        nx = m_x[k] + m_dx[k];
        ny = m_y[k] + m_dy[k];
        xmax = AW - m_w[k];
        ymax = AH - m_h[k];
        if (m_mode[k] == 1) begin
            if (nx < 0 || nx > xmax || ny < 0 || ny > ymax) begin
                m_st[k] = 2; m_ren[k] = 0; m_cnt[k] = RT;
            end else begin
                m_x[k] = nx; m_y[k] = ny;
            end
        end else if (m_mode[k] == 2) begin
            if (nx < 0) begin nx = 0; m_dx[k] = -m_dx[k]; end
            else if (nx > xmax) begin nx = xmax; m_dx[k] = -m_dx[k]; end
            if (ny < 0) begin ny = 0; m_dy[k] = -m_dy[k]; end
            else if (ny > ymax) begin ny = ymax; m_dy[k] = -m_dy[k]; end
            m_x[k] = nx; m_y[k] = ny;
        end else begin
            if (nx < 0) nx += AW; else if (nx >= AW) nx -= AW;
            if (ny < 0) ny += AH; else if (ny >= AH) ny -= AH;
            m_x[k] = nx; m_y[k] = ny;
        end
    endtask

    // One clock of the reference: hit uses the pre-edge outputs, then each channel advances.
    task automatic model_step();
        int px, py, pw, ph, idx;
        bit stepping;
        px = player_pos[15:8]; py = player_pos[7:0]; pw = player_size[15:8]; ph = player_size[7:0];
        stepping = frame_tick && is_run;
        for (int k = 0; k < NUM_CH; k++) begin
            m_hit[k] = (m_ren[k] != 0 && m_x[k] < px + pw && px < m_x[k] + m_w[k] &&
                        m_y[k] < py + ph && py < m_y[k] + m_h[k]) ? 1 : 0;
            idx = index[3*k +: 3];
            if (idx != m_idxq[k] || (m_st[k] == 0 && idx >= 1 && idx <= 3)) begin
                if (idx >= 1 && idx <= 3) model_load(k, idx);
                else begin
                    m_st[k] = 0; m_ren[k] = 0; m_x[k] = 0; m_y[k] = 0; m_w[k] = 0; m_h[k] = 0;
                    m_col[k] = 0; m_dx[k] = 0; m_dy[k] = 0;
                end
            end else if (m_st[k] == 2 && m_cnt[k] == 0) begin
                model_load(k, m_idxq[k]);
            end else if (m_st[k] == 1 && stepping) begin
                model_move(k);
            end else if (m_st[k] == 2 && stepping) begin
                m_cnt[k]--;
            end
            m_idxq[k] = idx;
        end
    endtask

    task automatic check_output();
        logic [16*NUM_CH-1:0] e_pos, e_size;
        logic [3*NUM_CH-1:0]  e_col;
        logic [NUM_CH-1:0]    e_ren, e_hit;
        for (int k = 0; k < NUM_CH; k++) begin
            e_pos[16*k +: 16] = {8'(m_x[k]), 8'(m_y[k])};
            e_size[16*k +: 16] = {8'(m_w[k]), 8'(m_h[k])};
            e_col[3*k +: 3] = 3'(m_col[k]);
            e_ren[k] = (m_ren[k] != 0);
            e_hit[k] = (m_hit[k] != 0);
        end
        checks++;
        assert (position === e_pos) else begin failures++; $error("FAIL position got=%h exp=%h", position, e_pos); end
        checks++;
        assert (size === e_size) else begin failures++; $error("FAIL size got=%h exp=%h", size, e_size); end
        checks++;
        assert (color === e_col) else begin failures++; $error("FAIL color got=%h exp=%h", color, e_col); end
        checks++;
        assert (is_render === e_ren) else begin failures++; $error("FAIL isRender got=%b exp=%b", is_render, e_ren); end
        checks++;
        assert (hit === e_hit) else begin failures++; $error("FAIL hit got=%b exp=%b", hit, e_hit); end
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin failures++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp); end
    endtask

    function automatic int bx(input int k); return int'(position[16*k+8 +: 8]); endfunction
    function automatic int by(input int k); return int'(position[16*k +: 8]); endfunction

    task automatic apply_stimulus();
        @(posedge clk);
        model_step();
        #1;
        check_output();
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        apply_stimulus();
        frame_tick = 1'b0;
        apply_stimulus();
    endtask

    initial begin
        model_reset();
        is_run = 1'b1;
        player_pos = {8'd200, 8'd200};
        player_size = {8'd4, 8'd4};
        #2;
        check_output();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        index = {3'd0, 3'd2, 3'd3, 3'd1};
        apply_stimulus();
        check_val("ch0_start_x", bx(0), 0);
        check_val("ch0_start_y", by(0), 60);
        check_val("ch0_size", int'(size[15:0]), 16'h0808);
        check_val("ch0_render", int'(is_render[0]), 1);

        for (int t = 1; t <= 118; t++) begin
            do_tick();
            case (t)
                5:   check_val("ch0_x_t5", bx(0), 10);
                50:  check_val("ch1_x_t50", bx(1), 0);
                51:  begin
                         check_val("ch1_wrap_x", bx(1), 157);
                         check_val("ch1_wrap_y", by(1), 60);
                         check_val("ch1_wrap_render", int'(is_render[1]), 1);
                     end
                76:  check_val("ch0_x_t76", bx(0), 152);
                77:  check_val("ch0_despawn_render", int'(is_render[0]), 0);
                80:  check_val("ch0_cooldown_render", int'(is_render[0]), 0);
                81:  begin
                         check_val("ch0_respawn_render", int'(is_render[0]), 1);
                         check_val("ch0_respawn_x", bx(0), 0);
                         check_val("ch0_respawn_y", by(0), 60);
                     end
                116: begin
                         check_val("ch2_x_t116", bx(2), 116);
                         check_val("ch2_y_t116", by(2), 116);
                     end
                117: begin
                         check_val("ch2_x_t117", bx(2), 117);
                         check_val("ch2_y_t117", by(2), 116);
                     end
                118: begin
                         check_val("ch2_x_t118", bx(2), 118);
                         check_val("ch2_y_t118", by(2), 115);
                     end
                default: ;
            endcase
        end

        player_pos = {8'd20, 8'd60};
        player_size = {8'd8, 8'd8};
        index[2:0] = 3'd0;
        apply_stimulus();
        check_val("ch0_idle_render", int'(is_render[0]), 0);
        index[2:0] = 3'd1;
        apply_stimulus();
        for (int t = 0; t < 10; t++) do_tick();
        check_val("ch0_hit_x", bx(0), 20);
        check_val("ch0_hit", int'(hit[0]), 1);
        is_run = 1'b0;
        for (int t = 0; t < 20; t++) do_tick();
        check_val("ch0_frozen_x", bx(0), 20);
        check_val("ch0_frozen_hit", int'(hit[0]), 1);
        is_run = 1'b1;
        index[2:0] = 3'd0;
        frame_tick = 1'b1;
        apply_stimulus();
        frame_tick = 1'b0;
        check_val("ch0_index0_tick_render", int'(is_render[0]), 0);

        $display("[TB] randomized phase");
        index = {3'd1, 3'd3, 3'd2, 3'd1};
        for (int i = 0; i < 1500; i++) begin
            int ch;
            frame_tick = ($urandom_range(0, 2) == 0);
            is_run = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 39) == 0) begin
                ch = $urandom_range(0, NUM_CH - 1);
                index[3*ch +: 3] = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 29) == 0) begin
                player_pos = {8'($urandom_range(0, 159)), 8'($urandom_range(0, 119))};
                player_size = {8'($urandom_range(1, 40)), 8'($urandom_range(1, 40))};
            end
            apply_stimulus();
        end
        frame_tick = 1'b0;

        index[2:0] = 3'd1;
        @(posedge clk);
        model_step();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output();
        @(posedge clk);
        #1;
        check_output();
        rst_n = 1'b1;
        apply_stimulus();
        check_val("post_reset_render", int'(is_render[0]), 1);
        check_val("post_reset_x", bx(0), 0);
        apply_stimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
